// File: rtl/cipher_queue.sv
// Synchronous FIFO that optionally XOR-encrypts words on write and can decrypt them
// on read with a per-entry stored key. DEPTH may be any value; pointers wrap by compare.
module cipher_queue #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 48,
    parameter int KEY_STORE = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Cen,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [WIDTH-1:0]           Data_in,
    input  logic [WIDTH-1:0]           Cipher_key,
    input  logic                       Cipher_en,
    input  logic                       Decrypt_en,
    output logic [WIDTH-1:0]           QUEUE_Data_Out,
    output logic                       QUEUE_Valid,
    output logic                       QUEUE_Empty,
    output logic                       QUEUE_Full,
    output logic                       QUEUE_Last,
    output logic [$clog2(DEPTH+1)-1:0] QUEUE_Count,
    output logic                       QUEUE_Overflow,
    output logic                       QUEUE_Underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] wr_word;
    logic [WIDTH-1:0] rd_word;

    // Request/accept semantics: wr_en/rd_en are requests sampled at a Cen=1 edge.
    // A read is accepted when the queue holds data; a write is accepted when there is
    // room, or when full and a read is accepted in the same cycle. Rejected requests
    // only raise the sticky overflow/underflow flags. QUEUE_Valid marks the cycle
    // after an accepted read, when QUEUE_Data_Out carries that word.
    always_comb begin
        rd_acc  = rd_en && (count != '0);
        wr_acc  = wr_en && ((count != CW'(DEPTH)) || rd_acc);
        wr_word = Cipher_en ? (Data_in ^ Cipher_key) : Data_in;
    end

    always_ff @(posedge clk) begin
        if (!reset && Cen && wr_acc) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    generate
        if (KEY_STORE != 0) begin : g_key
            logic [WIDTH-1:0] key_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (!reset && Cen && wr_acc) begin
                    key_mem[wr_ptr] <= Cipher_key;
                end
            end

            always_comb begin
                rd_word = mem[rd_ptr];
                if (Decrypt_en) begin
                    rd_word = mem[rd_ptr] ^ key_mem[rd_ptr];
                end
            end
        end else begin : g_nokey
            always_comb begin
                rd_word = mem[rd_ptr];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            QUEUE_Data_Out  <= '0;
            QUEUE_Valid     <= 1'b0;
            QUEUE_Overflow  <= 1'b0;
            QUEUE_Underflow <= 1'b0;
        end else if (Cen) begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr         <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
                QUEUE_Data_Out <= rd_word;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            QUEUE_Valid <= rd_acc;
            if (wr_en && !wr_acc) begin
                QUEUE_Overflow <= 1'b1;
            end
            if (rd_en && !rd_acc) begin
                QUEUE_Underflow <= 1'b1;
            end
        end
    end

    // Status is decoded purely from the registered count.
    assign QUEUE_Empty = (count == '0);
    assign QUEUE_Full  = (count == CW'(DEPTH));
    assign QUEUE_Last  = (count == CW'(DEPTH - 1));
    assign QUEUE_Count = count;

endmodule

// File: tb/tb_cipher_queue.sv
// Self-checking bench for cipher_queue (WIDTH=32, DEPTH=48, KEY_STORE=1) using a
// behavioural queue model and an expected-output scoreboard.
module tb_cipher_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 48;
    localparam logic [31:0] KEY_A = 32'hF23005FA;

    logic             clk = 1'b0;
    logic             reset;
    logic             Cen;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] Data_in;
    logic [WIDTH-1:0] Cipher_key;
    logic             Cipher_en;
    logic             Decrypt_en;
    logic [WIDTH-1:0] QUEUE_Data_Out;
    logic             QUEUE_Valid;
    logic             QUEUE_Empty;
    logic             QUEUE_Full;
    logic             QUEUE_Last;
    logic [5:0]       QUEUE_Count;
    logic             QUEUE_Overflow;
    logic             QUEUE_Underflow;

    cipher_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .KEY_STORE(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .Cen            (Cen),
        .wr_en          (wr_en),
        .rd_en          (rd_en),
        .Data_in        (Data_in),
        .Cipher_key     (Cipher_key),
        .Cipher_en      (Cipher_en),
        .Decrypt_en     (Decrypt_en),
        .QUEUE_Data_Out (QUEUE_Data_Out),
        .QUEUE_Valid    (QUEUE_Valid),
        .QUEUE_Empty    (QUEUE_Empty),
        .QUEUE_Full     (QUEUE_Full),
        .QUEUE_Last     (QUEUE_Last),
        .QUEUE_Count    (QUEUE_Count),
        .QUEUE_Overflow (QUEUE_Overflow),
        .QUEUE_Underflow(QUEUE_Underflow)
    );

    always #5 clk = ~clk;

    // Model state
    logic [WIDTH-1:0] m_mem[$];
    logic [WIDTH-1:0] m_key[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_dout;
    bit               m_valid;
    bit               m_ovf;
    bit               m_udf;
    int               n_cmp = 0;
    int               n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_status();
        int c;
        c = m_mem.size();
        check_eq("count", 32'(QUEUE_Count), 32'(c));
        check_eq("empty", 32'(QUEUE_Empty), 32'(c == 0));
        check_eq("full", 32'(QUEUE_Full), 32'(c == DEPTH));
        check_eq("last", 32'(QUEUE_Last), 32'(c == DEPTH - 1));
        check_eq("overflow", 32'(QUEUE_Overflow), 32'(m_ovf));
        check_eq("underflow", 32'(QUEUE_Underflow), 32'(m_udf));
        check_eq("valid", 32'(QUEUE_Valid), 32'(m_valid));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        Cen   = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        Cen   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        m_mem.delete();
        m_key.delete();
        exp_q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        check_status();
        check_eq("reset_dout", QUEUE_Data_Out, 32'h0);
    endtask

    // Drives one cycle of requests, advances the model, then checks outputs after the edge.
    task automatic step(input bit wr, input bit rd, input logic [31:0] d, input logic [31:0] k,
                        input bit cen, input bit cip, input bit dec);
        bit               w_ok;
        bit               r_ok;
        bit               fresh;
        logic [WIDTH-1:0] word;
        logic [WIDTH-1:0] key;
        logic [WIDTH-1:0] e;
        wr_en      = wr;
        rd_en      = rd;
        Data_in    = d;
        Cipher_key = k;
        Cen        = cen;
        Cipher_en  = cip;
        Decrypt_en = dec;
        fresh      = 1'b0;
        if (cen) begin
            r_ok = rd && (m_mem.size() > 0);
            w_ok = wr && ((m_mem.size() < DEPTH) || r_ok);
            if (rd && !r_ok) m_udf = 1'b1;
            if (wr && !w_ok) m_ovf = 1'b1;
            m_valid = r_ok;
            if (r_ok) begin
                word = m_mem.pop_front();
                key  = m_key.pop_front();
                exp_q.push_back(dec ? (word ^ key) : word);
                fresh = 1'b1;
            end
            if (w_ok) begin
                m_mem.push_back(cip ? (d ^ k) : d);
                m_key.push_back(k);
            end
        end
        @(posedge clk);
        #1;
        if (fresh) begin
            e = exp_q.pop_front();
            check_eq("rd_data", QUEUE_Data_Out, e);
            m_dout = e;
        end else begin
            check_eq("data_hold", QUEUE_Data_Out, m_dout);
        end
        check_status();
    endtask

    initial begin
        int op;
        reset      = 1'b1;
        Cen        = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        Data_in    = '0;
        Cipher_key = '0;
        Cipher_en  = 1'b0;
        Decrypt_en = 1'b0;
        do_reset();

        // Fill, then one write too many
        for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 32'(i), KEY_A, 1, 1, 0);
        // Drain without decryption, then one read too many
        for (int i = 0; i < DEPTH + 1; i++) step(0, 1, '0, '0, 1, 0, 0);

        // Per-entry keys with decrypt-on-read
        do_reset();
        step(1, 0, 32'h12345678, 32'h00000000, 1, 1, 0);
        step(1, 0, 32'h12345678, 32'hFFFFFFFF, 1, 1, 0);
        step(1, 0, 32'h12345678, 32'hA5A5A5A5, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, '0, '0, 1, 0, 1);

        // Simultaneous access when full, then when empty
        for (int i = 0; i < DEPTH; i++)
            step(1, 0, $urandom, $urandom, 1, 1'($urandom_range(0, 1)), 0);
        step(1, 1, 32'hCAFEF00D, 32'h0F0F0F0F, 1, 1, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 1, '0, '0, 1, 0, 1'($urandom_range(0, 1)));
        step(1, 1, 32'h5A5A0001, 32'h00FF00FF, 1, 1, 0);

        // Oscillate between 40 and 48 entries across pointer wrap
        while (m_mem.size() < 40) step(1, 0, $urandom, $urandom, 1, 1'($urandom_range(0, 1)), 0);
        for (int i = 0; i < 100; i++) begin
            op = $urandom_range(0, 2);
            if (op == 0 && m_mem.size() < DEPTH)
                step(1, 0, $urandom, $urandom, 1, 1'($urandom_range(0, 1)), 0);
            else if (op == 1 && m_mem.size() > 40)
                step(0, 1, '0, '0, 1, 0, 1'($urandom_range(0, 1)));
            else
                step(1, 1, $urandom, $urandom, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Chip enable low freezes everything
        step(0, 0, '0, '0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, $urandom, $urandom, 0, 1, 1);
        step(0, 1, '0, '0, 1, 0, 1);

        // Reset mid-queue at 20 entries, then confirm the queue still works
        while (m_mem.size() > 20) step(0, 1, '0, '0, 1, 0, 1);
        do_reset();
        step(1, 0, 32'hDEADBEEF, 32'h11111111, 1, 1, 0);
        step(0, 1, '0, '0, 1, 0, 1);

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
